// File: rtl/vc_pop_arbiter_pkg.sv
// Shared encodings and sizes for the VC pop arbiter: sequencer state codes,
// arbiter FSM codes, word width and VC count.
package vc_pop_arbiter_pkg;

  localparam int DATA_W    = 10;
  localparam int NUM_VC    = 4;
  localparam int VC_IDX_W  = 2;
  localparam int ROUTE_BIT = DATA_W - 1;

  typedef enum logic [3:0] {
    SM_RESET  = 4'b0001,
    SM_INIT   = 4'b0010,
    SM_IDLE   = 4'b0100,
    SM_ACTIVE = 4'b1000
  } sm_state_e;

  typedef enum logic [1:0] {
    FSM_WAIT  = 2'd0,
    FSM_ARB   = 2'd1,
    FSM_DRAIN = 2'd2
  } arb_fsm_e;

  function automatic logic [VC_IDX_W-1:0] onehot_to_idx(input logic [NUM_VC-1:0] oh);
    logic [VC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) idx = idx | VC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_rr_grant4.sv
// Four-way grant search. Round-robin from last+1 by default; fixed priority
// VC0>VC1>VC2>VC3 when VC_STRICT_PRIORITY_EN is defined.
module rr_grant4
  import vc_pop_arbiter_pkg::*;
(
  input  logic [NUM_VC-1:0]   req,
  input  logic [VC_IDX_W-1:0] last,
  output logic [NUM_VC-1:0]   grant
);

`ifdef VC_STRICT_PRIORITY_EN
  always_comb begin
    grant = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (req[i]) grant = NUM_VC'(1) << i;
    end
  end
`else
  logic [VC_IDX_W-1:0] idx;
  logic                found;

  // Offsets 1..4 wrap in two bits, so offset 4 revisits last itself.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = last + VC_IDX_W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops source VC FIFOs one word per cycle and routes each word to D0/D1 by its
// top bit; grant policy selectable with VC_STRICT_PRIORITY_EN (see rr_grant4).
//
// state     | meaning
// FSM_WAIT  | sequencer not ACTIVE, or pops gated by almost_full / all empty
// FSM_ARB   | a pop was issued this cycle
// FSM_DRAIN | sequencer left ACTIVE, words still in the pipeline
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [NUM_VC-1:0] vc_empty,
  input  logic [DATA_W-1:0] vc_data_0,
  input  logic [DATA_W-1:0] vc_data_1,
  input  logic [DATA_W-1:0] vc_data_2,
  input  logic [DATA_W-1:0] vc_data_3,
  input  logic [1:0]        dest_almost_full,
  output logic [NUM_VC-1:0] vc_pop,
  output logic [1:0]        dest_push,
  output logic [DATA_W-1:0] dest_data,
  output logic              idle
);

  arb_fsm_e            fsm_q, fsm_d;
  logic                sync_clr;
  logic                active;
  logic [NUM_VC-1:0]   req;
  logic [NUM_VC-1:0]   grant;
  logic                issue;
  logic                in_flight_next;
  logic [VC_IDX_W-1:0] last_grant_q;
  logic                tag_valid_q;
  logic [VC_IDX_W-1:0] tag_q;
  logic [DATA_W-1:0]   cap_word;

  assign sync_clr = reset || (state == SM_RESET);
  assign active   = (state == SM_ACTIVE);
  assign req      = ~vc_empty;
  assign issue    = active && (dest_almost_full == 2'b00) && (|req);

  rr_grant4 u_grant (
    .req   (req),
    .last  (last_grant_q),
    .grant (grant)
  );

  // Source FIFO output is valid the cycle after its pop; tag says which one.
  always_comb begin
    cap_word = vc_data_0;
    case (tag_q)
      2'd0:    cap_word = vc_data_0;
      2'd1:    cap_word = vc_data_1;
      2'd2:    cap_word = vc_data_2;
      default: cap_word = vc_data_3;
    endcase
  end

  assign in_flight_next = issue || (|vc_pop) || tag_valid_q;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_WAIT, FSM_ARB: begin
        if (issue)                          fsm_d = FSM_ARB;
        else if (!active && in_flight_next) fsm_d = FSM_DRAIN;
        else                                fsm_d = FSM_WAIT;
      end
      FSM_DRAIN: begin
        if (issue)                fsm_d = FSM_ARB;
        else if (!in_flight_next) fsm_d = FSM_WAIT;
      end
      default: fsm_d = FSM_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      fsm_q        <= FSM_WAIT;
      vc_pop       <= '0;
      last_grant_q <= VC_IDX_W'(NUM_VC - 1);
      tag_valid_q  <= 1'b0;
      tag_q        <= '0;
      dest_push    <= 2'b00;
      dest_data    <= '0;
    end else begin
      fsm_q       <= fsm_d;
      vc_pop      <= issue ? grant : '0;
      if (issue) last_grant_q <= onehot_to_idx(grant);
      tag_valid_q <= |vc_pop;
      tag_q       <= onehot_to_idx(vc_pop);
      if (tag_valid_q) begin
        dest_push <= cap_word[ROUTE_BIT] ? 2'b10 : 2'b01;
        dest_data <= cap_word;
      end else begin
        dest_push <= 2'b00;
      end
    end
  end

  assign idle = (vc_pop == '0) && !tag_valid_q && (dest_push == 2'b00);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Self-checking bench for vc_pop_arbiter: directed table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_vc_pop_arbiter;
  import vc_pop_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] st;
  logic [3:0] vc_empty;
  logic [9:0] vd [4];
  logic [1:0] af;
  logic [3:0] vc_pop;
  logic [1:0] dest_push;
  logic [9:0] dest_data;
  logic       idle;

  int checks = 0;
  int errors = 0;

  // reference model: VC indices as ints, -1 meaning "nothing"
  int         m_lg, m_pop, m_cap;
  logic [1:0] m_push;
  logic [9:0] m_data;

  always #5 clk = ~clk;

  vc_pop_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .state            (st),
    .vc_empty         (vc_empty),
    .vc_data_0        (vd[0]),
    .vc_data_1        (vd[1]),
    .vc_data_2        (vd[2]),
    .vc_data_3        (vd[3]),
    .dest_almost_full (af),
    .vc_pop           (vc_pop),
    .dest_push        (dest_push),
    .dest_data        (dest_data),
    .idle             (idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int c;
    if (reset || st == SM_RESET) begin
      m_pop = -1; m_cap = -1; m_push = 2'b00; m_data = '0; m_lg = 3;
    end else begin
      if (m_cap >= 0) begin
        m_data = vd[m_cap];
        m_push = m_data[9] ? 2'b10 : 2'b01;
      end else begin
        m_push = 2'b00;
      end
      m_cap = m_pop;
      m_pop = -1;
      if (st == SM_ACTIVE && af == 2'b00) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_lg + k) % 4;
          if (m_pop < 0 && !vc_empty[c]) m_pop = c;
        end
      end
      if (m_pop >= 0) m_lg = m_pop;
    end
    @(posedge clk);
    #1;
    chk("model_pop",  32'(vc_pop),    (m_pop < 0) ? 32'd0 : (32'd1 << m_pop));
    chk("model_push", 32'(dest_push), 32'(m_push));
    chk("model_data", 32'(dest_data), 32'(m_data));
    chk("model_idle", 32'(idle),      32'(m_pop < 0 && m_cap < 0 && m_push == 2'b00));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] st;
    logic [3:0] emp;
    logic [1:0] af;
    logic [3:0] pop;
    logic [1:0] push;
    logic [9:0] data;
    logic       idle;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [3:0] A, I;
    int pushes;
    A = SM_ACTIVE;
    I = SM_IDLE;
    // rst st emp af | pop push data idle
    tbl[0]  = '{1'b0, A, 4'b1110, 2'b00, 4'b0001, 2'b00, 10'h000, 1'b0};
    tbl[1]  = '{1'b0, I, 4'b1111, 2'b00, 4'b0000, 2'b00, 10'h000, 1'b0};
    tbl[2]  = '{1'b0, I, 4'b1111, 2'b00, 4'b0000, 2'b01, 10'h005, 1'b0};
    tbl[3]  = '{1'b0, I, 4'b1111, 2'b00, 4'b0000, 2'b00, 10'h005, 1'b1};
    tbl[4]  = '{1'b0, A, 4'b1101, 2'b00, 4'b0010, 2'b00, 10'h005, 1'b0};
    tbl[5]  = '{1'b0, I, 4'b1111, 2'b00, 4'b0000, 2'b00, 10'h005, 1'b0};
    tbl[6]  = '{1'b0, I, 4'b1111, 2'b00, 4'b0000, 2'b10, 10'h2A0, 1'b0};
    tbl[7]  = '{1'b0, I, 4'b1111, 2'b00, 4'b0000, 2'b00, 10'h2A0, 1'b1};
    tbl[8]  = '{1'b1, A, 4'b0000, 2'b00, 4'b0000, 2'b00, 10'h000, 1'b1};
    tbl[9]  = '{1'b0, A, 4'b0000, 2'b00, 4'b0001, 2'b00, 10'h000, 1'b0};
    tbl[10] = '{1'b0, A, 4'b0000, 2'b00, 4'b0010, 2'b00, 10'h000, 1'b0};
    tbl[11] = '{1'b0, A, 4'b0000, 2'b00, 4'b0100, 2'b01, 10'h005, 1'b0};
    tbl[12] = '{1'b0, A, 4'b0000, 2'b00, 4'b1000, 2'b10, 10'h2A0, 1'b0};
    tbl[13] = '{1'b0, A, 4'b0000, 2'b00, 4'b0001, 2'b01, 10'h133, 1'b0};
    tbl[14] = '{1'b0, I, 4'b0000, 2'b00, 4'b0000, 2'b10, 10'h3C7, 1'b0};
    tbl[15] = '{1'b0, I, 4'b0000, 2'b00, 4'b0000, 2'b01, 10'h005, 1'b0};
    tbl[16] = '{1'b0, I, 4'b0000, 2'b00, 4'b0000, 2'b00, 10'h005, 1'b1};

    m_lg = 3; m_pop = -1; m_cap = -1; m_push = 2'b00; m_data = '0;
    reset = 1'b1; st = SM_RESET; vc_empty = 4'hF; af = 2'b00;
    vd[0] = 10'h005; vd[1] = 10'h2A0; vd[2] = 10'h133; vd[3] = 10'h3C7;
    step();
    step();
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_pop",  32'(vc_pop), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < 17; r++) begin
      reset = tbl[r].rst; st = tbl[r].st; vc_empty = tbl[r].emp; af = tbl[r].af;
      step();
      chk($sformatf("tbl%0d_pop", r),  32'(vc_pop),    32'(tbl[r].pop));
      chk($sformatf("tbl%0d_push", r), 32'(dest_push), 32'(tbl[r].push));
      chk($sformatf("tbl%0d_data", r), 32'(dest_data), 32'(tbl[r].data));
      chk($sformatf("tbl%0d_idle", r), 32'(idle),      32'(tbl[r].idle));
    end

    // almost_full gating with a word already in flight
    reset = 1'b1; step(); reset = 1'b0;
    st = SM_ACTIVE; vc_empty = 4'b0000; af = 2'b00;
    step();
    chk("af_first_pop", 32'(vc_pop), 32'b0001);
    af = 2'b01;
    pushes = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("af_gated_pop", 32'(vc_pop), 32'd0);
      if (dest_push != 2'b00) pushes++;
    end
    chk("af_inflight_pushes", 32'(pushes), 32'd1);
    af = 2'b00;
    step();
    chk("af_release_pop", 32'(vc_pop), 32'b0010);

    // reset one cycle after a pop discards the word
    reset = 1'b1; step(); reset = 1'b0;
    st = SM_ACTIVE; vc_empty = 4'b1110;
    step();
    chk("rst_mid_pop", 32'(vc_pop), 32'b0001);
    reset = 1'b1;
    step();
    chk("rst_mid_push0", 32'(dest_push), 32'd0);
    reset = 1'b0; st = SM_IDLE;
    step();
    chk("rst_mid_push1", 32'(dest_push), 32'd0);
    st = SM_ACTIVE; vc_empty = 4'b0000;
    step();
    chk("rst_mid_regrant", 32'(vc_pop), 32'b0001);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      reset = ($urandom_range(99) < 2);
      sel = $urandom_range(9);
      if (sel < 6)       st = SM_ACTIVE;
      else if (sel == 6) st = SM_IDLE;
      else if (sel == 7) st = SM_INIT;
      else if (sel == 8) st = SM_RESET;
      else               st = SM_ACTIVE;
      vc_empty = 4'($urandom);
      af = ($urandom_range(9) < 3) ? 2'($urandom) : 2'b00;
      for (int i = 0; i < 4; i++) vd[i] = 10'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
